// File: rtl/epl_fi_wrfail_seq_pkg.sv
// Shared definitions for the sequential write-failure fault injector:
// default widths, corruption-mode and arm/clear state encodings.
package epl_fi_wrfail_seq_pkg;

  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_WORD        = 64;
  localparam int DEF_TWORD_WIDTH = 39;
  localparam int DEF_FAULT       = 8;
  localparam int DEF_CNT_WIDTH   = 8;

  // Bit index of the fault-select vector that enables this injection point.
  localparam int FI1_SEL_BIT = 0;

  typedef enum logic [1:0] {
    FI_FLIP   = 2'd0,
    FI_FORCE0 = 2'd1,
    FI_FORCE1 = 2'd2,
    FI_STUCK  = 2'd3
  } fi_mode_t;

  typedef enum logic [1:0] {
    FI_IDLE      = 2'd0,
    FI_ARMED     = 2'd1,
    FI_EXHAUSTED = 2'd2
  } fi_state_t;

endpackage

// File: rtl/epl_fi_wrfail_seq_corrupt.sv
// Combinational codeword corruption shared by fault-injection points:
// applies the selected mode to the incoming codeword.
module epl_fi_corrupt
  import epl_fi_wrfail_seq_pkg::*;
#(
  parameter int TWORD_WIDTH = DEF_TWORD_WIDTH
) (
  input  fi_mode_t               mode,
  input  logic [TWORD_WIDTH-1:0] bit_mask,
  input  logic [TWORD_WIDTH-1:0] stuck_val,
  input  logic [TWORD_WIDTH-1:0] cw,
  output logic [TWORD_WIDTH-1:0] cw_out
);

  always_comb begin
    cw_out = cw;
    unique case (mode)
      FI_FLIP:   cw_out = cw ^ bit_mask;
      FI_FORCE0: cw_out = '0;
      FI_FORCE1: cw_out = '1;
      FI_STUCK:  cw_out = (cw & ~bit_mask) | (stuck_val & bit_mask);
      default:   cw_out = cw;
    endcase
  end

endmodule

// File: rtl/epl_fi_wrfail_seq.sv
// Sequential write-path fault injector: one register stage between ECC encode
// and column access, with periodic triggering, an injection budget and arm/clear.
module epl_fi_wrfail_seq
  import epl_fi_wrfail_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WORD        = DEF_WORD,
  parameter int TWORD_WIDTH = DEF_TWORD_WIDTH,
  parameter int FAULT       = DEF_FAULT,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   pCLK_i,
  input  logic                   pRST_i,
  input  logic [ADDR_WIDTH-1:0]  pA_i,
  input  logic                   pWRITE_i,
  input  logic [TWORD_WIDTH-1:0] pCODEWORD_i,
  input  logic [FAULT-1:0]       pFS_i,
  input  logic [WORD-1:0]        pFiWordMask_i,
  input  logic [TWORD_WIDTH-1:0] pFiBitMask_i,
  input  logic [TWORD_WIDTH-1:0] pFiStuckVal_i,
  input  logic [1:0]             pFiMode_i,
  input  logic [CNT_WIDTH-1:0]   pFiPeriod_i,
  input  logic [CNT_WIDTH-1:0]   pFiBudget_i,
  input  logic                   pFiArm_i,
  input  logic                   pFiClr_i,
  output logic [ADDR_WIDTH-1:0]  pA_o,
  output logic                   pWRITE_o,
  output logic [TWORD_WIDTH-1:0] pCODEWORD_o,
  output logic                   pFiHit_o,
  output logic [CNT_WIDTH-1:0]   pFiCount_o,
  output logic                   pFiArmed_o,
  output logic                   pFiDone_o
);

  localparam int ADDR_SPAN = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  fi_state_t              state_reg, state_next;
  logic [CNT_WIDTH-1:0]   per_cnt_reg, per_cnt_next;
  logic [CNT_WIDTH-1:0]   fi_cnt_reg, fi_cnt_next;
  logic [CNT_WIDTH-1:0]   period_m1;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic [ADDR_SPAN-1:0]   word_sel;
  logic                   hit;
  logic                   inject;
  logic [TWORD_WIDTH-1:0] cw_corrupt;

  logic [ADDR_WIDTH-1:0]  a_reg;
  logic                   write_reg;
  logic [TWORD_WIDTH-1:0] cw_reg;
  logic                   hit_reg;

  // Addresses beyond the covered word range read as "not targeted".
  generate
    for (genvar gi = 0; gi < ADDR_SPAN; gi++) begin : g_word_sel
      if (gi < WORD) begin : g_in
        assign word_sel[gi] = pFiWordMask_i[gi];
      end else begin : g_out
        assign word_sel[gi] = 1'b0;
      end
    end
  endgenerate

  assign hit       = pWRITE_i & pFS_i[FI1_SEL_BIT] & word_sel[pA_i];
  assign period_m1 = (pFiPeriod_i == '0) ? '0 : pFiPeriod_i - CNT_ONE;
  assign cnt_inc   = (&fi_cnt_reg) ? fi_cnt_reg : fi_cnt_reg + CNT_ONE;

  epl_fi_corrupt #(
    .TWORD_WIDTH (TWORD_WIDTH)
  ) u_corrupt (
    .mode      (fi_mode_t'(pFiMode_i)),
    .bit_mask  (pFiBitMask_i),
    .stuck_val (pFiStuckVal_i),
    .cw        (pCODEWORD_i),
    .cw_out    (cw_corrupt)
  );

  always_ff @(posedge pCLK_i) begin
    if (pRST_i) begin
      state_reg   <= FI_IDLE;
      per_cnt_reg <= '0;
      fi_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      per_cnt_reg <= per_cnt_next;
      fi_cnt_reg  <= fi_cnt_next;
    end
  end

  // Clear beats arm; arm in the same cycle as a hit suppresses that injection.
  always_comb begin
    state_next   = state_reg;
    per_cnt_next = per_cnt_reg;
    fi_cnt_next  = fi_cnt_reg;
    inject       = 1'b0;
    if (pFiClr_i) begin
      state_next   = FI_IDLE;
      per_cnt_next = '0;
      fi_cnt_next  = '0;
    end else if (pFiArm_i) begin
      state_next   = FI_ARMED;
      per_cnt_next = '0;
      fi_cnt_next  = '0;
    end else if (state_reg == FI_ARMED && hit) begin
      if (per_cnt_reg == period_m1) begin
        inject       = 1'b1;
        per_cnt_next = '0;
        fi_cnt_next  = cnt_inc;
        if (pFiBudget_i != '0 && cnt_inc == pFiBudget_i) begin
          state_next = FI_EXHAUSTED;
        end
      end else begin
        per_cnt_next = per_cnt_reg + CNT_ONE;
      end
    end
  end

  always_comb begin
    pFiArmed_o = (state_reg == FI_ARMED);
    pFiDone_o  = (state_reg == FI_EXHAUSTED);
    pFiCount_o = fi_cnt_reg;
  end

  always_ff @(posedge pCLK_i) begin
    if (pRST_i) begin
      a_reg     <= '0;
      write_reg <= 1'b0;
      cw_reg    <= '0;
      hit_reg   <= 1'b0;
    end else begin
      a_reg     <= pA_i;
      write_reg <= pWRITE_i;
      cw_reg    <= inject ? cw_corrupt : pCODEWORD_i;
      hit_reg   <= inject;
    end
  end

  assign pA_o        = a_reg;
  assign pWRITE_o    = write_reg;
  assign pCODEWORD_o = cw_reg;
  assign pFiHit_o    = hit_reg;

endmodule

// File: tb/tb_epl_fi_wrfail_seq.sv
// Scoreboard bench for epl_fi_wrfail_seq: directed scenarios, counter
// saturation and randomized traffic checked against a behavioural model.
module tb_epl_fi_wrfail_seq;

  localparam int AW = 6;
  localparam int WD = 64;
  localparam int TW = 39;
  localparam int FS = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] a = '0;
  logic          wr = 1'b0;
  logic [TW-1:0] cw = '0;
  logic [FS-1:0] fs = '0;
  logic [WD-1:0] wmask = '0;
  logic [TW-1:0] bmask = '0;
  logic [TW-1:0] stuck = '0;
  logic [1:0]    mode = '0;
  logic [CW-1:0] period = '0;
  logic [CW-1:0] budget = '0;
  logic          arm = 1'b0;
  logic          clr = 1'b0;

  logic [AW-1:0] a_o;
  logic          wr_o;
  logic [TW-1:0] cw_o;
  logic          hit_o;
  logic [CW-1:0] cnt_o;
  logic          armed_o;
  logic          done_o;

  epl_fi_wrfail_seq #(
    .ADDR_WIDTH(AW), .WORD(WD), .TWORD_WIDTH(TW), .FAULT(FS), .CNT_WIDTH(CW)
  ) dut (
    .pCLK_i(clk), .pRST_i(rst), .pA_i(a), .pWRITE_i(wr), .pCODEWORD_i(cw),
    .pFS_i(fs), .pFiWordMask_i(wmask), .pFiBitMask_i(bmask), .pFiStuckVal_i(stuck),
    .pFiMode_i(mode), .pFiPeriod_i(period), .pFiBudget_i(budget),
    .pFiArm_i(arm), .pFiClr_i(clr),
    .pA_o(a_o), .pWRITE_o(wr_o), .pCODEWORD_o(cw_o), .pFiHit_o(hit_o),
    .pFiCount_o(cnt_o), .pFiArmed_o(armed_o), .pFiDone_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          wr;
    logic [TW-1:0] cw;
    logic          hit;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          done;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   failed = 0;

  // Reference model: 0 idle, 1 armed, 2 exhausted; hits since last injection.
  int m_mode_st = 0;
  int m_hits = 0;
  int m_count = 0;
  int max_count = (1 << CW) - 1;

  function automatic logic [TW-1:0] ref_corrupt(input logic [1:0] md,
      input logic [TW-1:0] c, input logic [TW-1:0] m, input logic [TW-1:0] s);
    logic [TW-1:0] r;
    case (md)
      2'd0: r = c ^ m;
      2'd1: r = '0;
      2'd2: r = '1;
      default: r = (c & ~m) | (s & m);
    endcase
    return r;
  endfunction

  function automatic obs_t model_step();
    obs_t e;
    bit   h;
    bit   inj;
    int   per;
    e = '0;
    if (rst) begin
      m_mode_st = 0; m_hits = 0; m_count = 0;
      return e;
    end
    h   = wr && fs[0] && (int'(a) < WD) && wmask[a];
    inj = 1'b0;
    per = (period == 0) ? 1 : int'(period);
    if (clr) begin
      m_mode_st = 0; m_hits = 0; m_count = 0;
    end else if (arm) begin
      m_mode_st = 1; m_hits = 0; m_count = 0;
    end else if (m_mode_st == 1 && h) begin
      m_hits++;
      if (m_hits == per) begin
        inj = 1'b1;
        m_hits = 0;
        if (m_count < max_count) m_count++;
        if (budget != 0 && m_count == int'(budget)) m_mode_st = 2;
      end
    end
    e.a     = a;
    e.wr    = wr;
    e.cw    = inj ? ref_corrupt(mode, cw, bmask, stuck) : cw;
    e.hit   = inj;
    e.cnt   = CW'(m_count);
    e.armed = (m_mode_st == 1);
    e.done  = (m_mode_st == 2);
    return e;
  endfunction

  // One clock: predict from the current inputs, then queue after the edge.
  task automatic cycle();
    obs_t e;
    e = model_step();
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [TW-1:0] data);
    a = addr; cw = data; wr = 1'b1;
    cycle();
    wr = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; cycle(); arm = 1'b0;
  endtask

  function automatic logic [TW-1:0] rand_cw();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[TW-1:0];
  endfunction

  always @(negedge clk) begin
    obs_t e;
    obs_t act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = '{a: a_o, wr: wr_o, cw: cw_o, hit: hit_o, cnt: cnt_o,
              armed: armed_o, done: done_o};
      tests++;
      if (act !== e) begin
        failed++;
        $display("FAIL outputs: got a=%0d wr=%0b cw=%h hit=%0b cnt=%0d armed=%0b done=%0b, expected a=%0d wr=%0b cw=%h hit=%0b cnt=%0d armed=%0b done=%0b",
                 act.a, act.wr, act.cw, act.hit, act.cnt, act.armed, act.done,
                 e.a, e.wr, e.cw, e.hit, e.cnt, e.armed, e.done);
      end
    end
  end

  initial begin
    logic [63:0] wm;
    #1;
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;

    // FLIP, period 1, unlimited, word 5 targeted, bit 0 flipped
    fs = 8'h01; wmask = '0; wmask[5] = 1'b1; bmask = 39'h1;
    mode = 2'd0; period = 8'd1; budget = 8'd0;
    pulse_arm();
    write_word(6'd5, 39'h00_0000_00AA);
    write_word(6'd6, 39'h00_0000_00AA);
    cycle();

    // FORCE0 every third hit
    mode = 2'd1; period = 8'd3;
    pulse_arm();
    repeat (6) write_word(6'd5, rand_cw());

    // FORCE1 with a budget of two
    mode = 2'd2; period = 8'd1; budget = 8'd2;
    pulse_arm();
    repeat (3) write_word(6'd5, rand_cw());

    // STUCK, then clear back to idle
    mode = 2'd3; bmask = 39'hF; stuck = 39'h5; budget = 8'd0;
    pulse_arm();
    write_word(6'd5, 39'hA3);
    clr = 1'b1; cycle(); clr = 1'b0;
    write_word(6'd5, 39'hA3);

    // Arm collides with a hit; then a write with the select bit off
    pulse_arm();
    write_word(6'd5, rand_cw());
    arm = 1'b1; write_word(6'd5, rand_cw()); arm = 1'b0;
    fs = 8'hFE; write_word(6'd5, rand_cw());
    fs = 8'h01;

    // Reset in the middle of a write
    rst = 1'b1; write_word(6'd5, rand_cw()); rst = 1'b0;
    cycle();

    // Count saturation with an unlimited budget
    mode = 2'd0; bmask = 39'h3; period = 8'd1; budget = 8'd0;
    pulse_arm();
    repeat (260) write_word(6'd5, rand_cw());

    // Randomized traffic; period and budget change only together with arm
    for (int i = 0; i < 500; i++) begin
      wm    = {$urandom(), $urandom()};
      wmask = wm;
      a     = AW'($urandom_range(0, (1 << AW) - 1));
      cw    = rand_cw();
      wr    = ($urandom_range(0, 3) != 0);
      fs    = FS'($urandom_range(0, 255)) | FS'($urandom_range(0, 3) != 0);
      mode  = 2'($urandom_range(0, 3));
      bmask = rand_cw();
      stuck = rand_cw();
      arm   = ($urandom_range(0, 19) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      if (arm) begin
        period = CW'($urandom_range(0, 4));
        budget = CW'($urandom_range(0, 3));
      end
      cycle();
    end
    wr = 1'b0; arm = 1'b0; clr = 1'b0; rst = 1'b0;

    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/epl_fi_wrfail_seq.md
# epl_fi_wrfail_seq

Parametrised, sequential successor to the combinational write-failure fault injector (FI-1). It sits between the ECC encoder and column access on the write path. It adds a registered pipeline stage, four corruption modes, periodic (every Nth hit) triggering, an injection budget and an arm/clear state machine. Status outputs let the bench and BIST logic count and observe every injected write.

## Interface
Parameters:
- ADDR_WIDTH, 6, word address width
- WORD, 64, number of words covered by the word mask (≤ 2^ADDR_WIDTH)
- TWORD_WIDTH, 39, codeword width (data + ECC)
- FAULT, 8, fault-select vector width; bit 0 enables FI-1
- CNT_WIDTH, 8, width of period, budget and injection counters

Ports:
- pCLK_i  in  1  clock
- pRST_i  in  1  reset; synchronous, active-high
- pA_i  in  ADDR_WIDTH  write address
- pWRITE_i  in  1  write strobe; qualifies the other inputs in that cycle
- pCODEWORD_i  in  TWORD_WIDTH  encoded codeword
- pFS_i  in  FAULT  fault select
- pFiWordMask_i  in  WORD  per-word target mask
- pFiBitMask_i  in  TWORD_WIDTH  bit selection for the flip and stuck modes
- pFiStuckVal_i  in  TWORD_WIDTH  stuck value (STUCK mode)
- pFiMode_i  in  2  0 FLIP, 1 FORCE0, 2 FORCE1, 3 STUCK
- pFiPeriod_i  in  CNT_WIDTH  inject on every Nth hit; 0 is treated as 1
- pFiBudget_i  in  CNT_WIDTH  maximum number of injections; 0 means unlimited
- pFiArm_i  in  1  pulse: arm the block and clear its counters
- pFiClr_i  in  1  pulse: disarm the block and clear its counters
- pA_o  out  ADDR_WIDTH  registered address
- pWRITE_o  out  1  registered write strobe
- pCODEWORD_o  out  TWORD_WIDTH  registered, possibly corrupted codeword
- pFiHit_o  out  1  high with pWRITE_o when that write was corrupted
- pFiCount_o  out  CNT_WIDTH  injections since the last arm; saturates at all-ones
- pFiArmed_o  out  1  state == ARMED
- pFiDone_o  out  1  state == EXHAUSTED

## Operation
Qualifying hit: hit = pWRITE_i & pFS_i[0] & pFiWordMask_i[pA_i]. If pA_i ≥ WORD, hit is 0.

State machine (priority: pRST_i > pFiClr_i > pFiArm_i):
- IDLE: pass-through with no injection. pFiArm_i moves to ARMED.
- ARMED:
  - Each hit increments the period counter perCnt.
  - inject = hit & (perCnt == max(pFiPeriod_i,1) − 1).
  - On inject: perCnt ← 0 and pFiCount_o increments.
  - If the budget is nonzero and this injection brings the count to the budget, move to EXHAUSTED.
- EXHAUSTED: pass-through with no injection. pFiArm_i moves to ARMED.
- pFiArm_i in any state (including ARMED) clears perCnt and pFiCount_o and enters ARMED.
- pFiClr_i in any state clears perCnt and pFiCount_o and enters IDLE.

Corruption, applied only to injected writes:
- FLIP: cw ^ mask
- FORCE0: all zeros
- FORCE1: all ones
- STUCK: (cw & ~mask) | (stuck & mask)

Other rules:
- Mode, masks and period are sampled live in the write cycle. Changing them is legal at any time.
- The budget is compared against the count after the increment.
- If pFiArm_i and a hit occur in the same cycle, the arm wins: no injection that cycle and the counters end at 0.
- Non-write cycles pass through the pipeline unchanged (pWRITE_o = 0, pFiHit_o = 0). Address and codeword are still registered.

## Timing
- Latency is exactly 1 cycle, input to all p*_o data outputs. There is no back-pressure and no bubbles.
- pFiArmed_o, pFiDone_o and pFiCount_o reflect the state after the clock edge that processes the event. Example: the write that exhausts the budget shows pFiHit_o = 1 and pFiDone_o = 1 in the same output cycle.
- Reset values: all outputs 0 (pCODEWORD_o = 0, pA_o = 0, pWRITE_o = 0, pFiHit_o = 0, pFiCount_o = 0, pFiArmed_o = 0, pFiDone_o = 0). State is IDLE and perCnt = 0.
- Reset asserted mid-operation discards the in-flight write: pWRITE_o = 0 in the following cycle.
- pFiCount_o saturates at 2^CNT_WIDTH − 1 with an unlimited budget. perCnt wraps only through the period match.

## Structure
- Shared package: mode encodings (FI_FLIP, FI_FORCE0, FI_FORCE1, FI_STUCK) and state encodings (FI_IDLE, FI_ARMED, FI_EXHAUSTED), added alongside the existing `EPLFFRAM02_spec.vh` widths.
- One sub-module, epl_fi_corrupt: purely combinational; takes mode, masks and codeword and returns the corrupted codeword. It is reusable by later FI points.
- The top level holds the FSM, the counters and the output register.

## Test plan
- Reset, then arm, mode FLIP, period 1, budget 0, mask bit 5 set, BitMask = 0x1: write cw = 0x0_0000_00AA to A = 5 → next cycle pCODEWORD_o = 0x0_0000_00AB, pFiHit_o = 1, pFiCount_o = 1. A write to A = 6 passes unchanged.
- Period 3, FORCE0: six hits to A = 5 → hits 3 and 6 output 0; the others pass through. pFiCount_o = 2.
- Budget 2, FORCE1: three hits → the first two output all-ones; pFiDone_o rises with the second. The third passes through and pFiArmed_o = 0.
- STUCK, mask 0xF, stuck 0x5, cw = 0xA3 → output 0xA5. Then pFiClr_i → IDLE; the same write passes through and pFiCount_o = 0.
- Arm asserted in the same cycle as a hit while ARMED → no injection and pFiCount_o = 0. Hit with pFS_i[0] = 0 → no injection.
- Reset asserted during a write → pWRITE_o = 0 and all status outputs 0 in the next cycle.
